hyperbus_wb_bridge: RTL and testbench
=====================================

Name: hyperbus_wb_bridge

Overview:
- Wishbone classic slave (32-bit data, byte address) directly upstream of the hyperbus DDR controller.
- Converts each Wishbone access into one 2-word hyperbus burst. Drives the controller's adr/dat/mask/wrq/rrq/reg_space and consumes its ready/valid/dat_o.
- Returns ack after both 16-bit words are transferred, or err on timeout.

Parameters:
- ADDR_LENGTH, 32, width of hyperbus word address driven to controller.
- WB_ADR_WIDTH, 32, width of Wishbone byte address.
- REG_SPACE_BIT, 31, wb_adr_i bit that selects HyperRAM register space.
- TIMEOUT_CYCLES, 1024, cycles from request assertion to abort; counter width $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  memory clock, same clock as controller.
- rstn  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  WB_ADR_WIDTH  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer complete.
- wb_err_o  out  1  transfer aborted by timeout.
- hb_adr_o  out  ADDR_LENGTH  16-bit word address to controller.
- hb_dat_o  out  16  write word to controller.
- hb_mask_o  out  2  per-byte write mask, 1 = masked (RWDS semantics).
- hb_reg_space_o  out  1  register-space select.
- hb_wrq_o  out  1  write request, held for whole burst.
- hb_rrq_o  out  1  read request, held for whole burst.
- hb_dat_i  in  16  read word from controller.
- hb_ready_i  in  1  controller consumes hb_dat_o this cycle.
- hb_valid_i  in  1  hb_dat_i holds a valid read word this cycle.

Behaviour:
- Reset (rstn low, async): state IDLE. wb_ack_o, wb_err_o, hb_wrq_o, hb_rrq_o = 0. wb_dat_o, hb_adr_o, hb_dat_o = 0. hb_mask_o = 2'b11. hb_reg_space_o = 0. Word index and timeout counter = 0.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - On wb_cyc_i & wb_stb_i, latch address, data, sel, we.
  - hb_adr_o = wb_adr_i[ADDR_LENGTH:1] (byte address >> 1, zero-extended if narrower).
  - hb_reg_space_o = wb_adr_i[REG_SPACE_BIT].
  - Word index = 0, timeout = 0.
  - Next cycle: hb_wrq_o=1 and go to WRITE if we, else hb_rrq_o=1 and go to READ.
- Word order: word 0 = data[31:16], mask ~sel[3:2]; word 1 = data[15:0], mask ~sel[1:0].
- WRITE:
  - hb_dat_o/hb_mask_o present the current word combinationally from the word index.
  - Each cycle with hb_ready_i=1 consumes one word and advances the index.
  - On the cycle word 1 is consumed: clear hb_wrq_o (registered, low the next cycle), go to DONE.
  - hb_ready_i seen while hb_wrq_o=0 is ignored.
- READ:
  - Each hb_valid_i=1 cycle captures hb_dat_i: index 0 into wb_dat_o[31:16], index 1 into wb_dat_o[15:0].
  - On the word-1 capture: clear hb_rrq_o, go to DONE.
  - hb_valid_i while hb_rrq_o=0 is ignored.
- DONE: wb_ack_o=1 for exactly one cycle, then IDLE. No new request is accepted in the DONE cycle.
- Min latency, stb to ack: 1 (IDLE latch) + controller latency + 1.
- Timeout:
  - Counter increments each cycle in WRITE/READ and clears on every consumed/captured word.
  - On reaching TIMEOUT_CYCLES: drop both requests, pulse wb_err_o for one cycle (no ack), go to IDLE.
  - wb_dat_o on err is undefined for verification purposes.
- Abort: wb_cyc_i low in WRITE/READ drops the request next cycle and returns to IDLE with no ack/err. A partial write is permitted to reach memory.
- wb_ack_o and wb_err_o are never high together, and are never high outside a cycle the bridge accepted.
- Back-to-back: a new stb in the cycle after ack is latched normally. The controller's idle recovery appears as latency only; the bridge holds its request until served.
- Mask 2'b11 on both words (sel=0) still issues a full burst and acks.

Test Plan:
- Write wb_adr=0x0000_0010, dat=0xDEAD_BEEF, sel=4'hF, model ready on 2 cycles -> hb_adr=0x8, words 0xDEAD then 0xBEEF, mask 2'b00 both, wrq drops after 2nd ready, single ack.
- Read wb_adr=0x0000_0020, model valid with 0x1234 then 0x5678 (gap of 3 cycles between) -> hb_adr=0x10, rrq held through gap, wb_dat_o=0x1234_5678 on ack cycle.
- Write sel=4'b0010, dat=0xAABB_CCDD -> mask word0=2'b11, word1=2'b01; ack after 2 ready cycles.
- Read with wb_adr[31]=1 -> hb_reg_space_o=1, rrq asserted; model never asserts valid -> after TIMEOUT_CYCLES rrq=0, wb_err_o pulses 1 cycle, no ack.
- Drop wb_cyc_i after first ready of a write -> wrq low next cycle, state IDLE, no ack/err. Next write completes normally.
- Assert rstn=0 mid-read between valid words -> outputs immediately at reset values; after release, the first access completes with correct data.

Source files
------------

// File: rtl/hyperbus_wb_bridge_if.sv
// Bus bundle between a Wishbone host, the hyperbus_wb_bridge and the hyperbus DDR controller.
// The bridge uses 'slave'; the host/controller side uses 'master'.
interface hyperbus_wb_bridge_if #(
  parameter int unsigned ADDR_LENGTH  = 32,
  parameter int unsigned WB_ADR_WIDTH = 32
);
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [WB_ADR_WIDTH-1:0] wb_adr_i;
  logic [31:0]             wb_dat_i;
  logic [3:0]              wb_sel_i;
  logic [31:0]             wb_dat_o;
  logic                    wb_ack_o;
  logic                    wb_err_o;
  logic [ADDR_LENGTH-1:0]  hb_adr_o;
  logic [15:0]             hb_dat_o;
  logic [1:0]              hb_mask_o;
  logic                    hb_reg_space_o;
  logic                    hb_wrq_o;
  logic                    hb_rrq_o;
  logic [15:0]             hb_dat_i;
  logic                    hb_ready_i;
  logic                    hb_valid_i;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
           hb_dat_i, hb_ready_i, hb_valid_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
           hb_adr_o, hb_dat_o, hb_mask_o, hb_reg_space_o, hb_wrq_o, hb_rrq_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
           hb_dat_i, hb_ready_i, hb_valid_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
           hb_adr_o, hb_dat_o, hb_mask_o, hb_reg_space_o, hb_wrq_o, hb_rrq_o
  );
endinterface

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone classic slave that turns each 32-bit access into one 2-word hyperbus burst,
// high half first, with a per-burst stall timeout reported as wb_err_o.
module hyperbus_wb_bridge #(
  parameter int unsigned ADDR_LENGTH    = 32,
  parameter int unsigned WB_ADR_WIDTH   = 32,
  parameter int unsigned REG_SPACE_BIT  = 31,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  hyperbus_wb_bridge_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             r_state;
  logic [31:0]            r_dat;
  logic [3:0]             r_sel;
  logic                   r_idx;
  logic [TW-1:0]          r_to;
  logic                   r_ack;
  logic                   r_err;
  logic                   r_wrq;
  logic                   r_rrq;
  logic [31:0]            r_rdat;
  logic [ADDR_LENGTH-1:0] r_hb_adr;
  logic                   r_reg;

  logic [ADDR_LENGTH-1:0] w_hb_adr;
  logic                   w_beat;

  // Byte address to 16-bit word address, zero-extended or truncated to ADDR_LENGTH.
  assign w_hb_adr = ADDR_LENGTH'({{ADDR_LENGTH{1'b0}}, bus.wb_adr_i} >> 1);

  assign w_beat = (r_state == S_WRITE) ? (bus.hb_ready_i & r_wrq)
                                       : (bus.hb_valid_i & r_rrq);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_dat    <= '0;
      r_sel    <= '0;
      r_idx    <= 1'b0;
      r_to     <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_wrq    <= 1'b0;
      r_rrq    <= 1'b0;
      r_rdat   <= '0;
      r_hb_adr <= '0;
      r_reg    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The host still holds stb during the err cycle; do not re-accept that access.
          if (bus.wb_cyc_i && bus.wb_stb_i && !r_err) begin
            r_dat    <= bus.wb_dat_i;
            r_sel    <= bus.wb_sel_i;
            r_hb_adr <= w_hb_adr;
            r_reg    <= bus.wb_adr_i[REG_SPACE_BIT];
            r_idx    <= 1'b0;
            r_to     <= '0;
            if (bus.wb_we_i) begin
              r_wrq   <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_rrq   <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_WRITE, S_READ: begin
          if (!bus.wb_cyc_i) begin
            r_wrq   <= 1'b0;
            r_rrq   <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_beat) begin
            r_to <= '0;
            if (r_state == S_READ) begin
              if (r_idx) r_rdat[15:0]  <= bus.hb_dat_i;
              else       r_rdat[31:16] <= bus.hb_dat_i;
            end
            if (r_idx) begin
              r_wrq   <= 1'b0;
              r_rrq   <= 1'b0;
              r_ack   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx <= 1'b1;
            end
          end else if (r_to == TO_LAST) begin
            r_wrq   <= 1'b0;
            r_rrq   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_dat_o       = r_rdat;
  assign bus.wb_ack_o       = r_ack;
  assign bus.wb_err_o       = r_err;
  assign bus.hb_adr_o       = r_hb_adr;
  assign bus.hb_reg_space_o = r_reg;
  assign bus.hb_wrq_o       = r_wrq;
  assign bus.hb_rrq_o       = r_rrq;
  assign bus.hb_dat_o       = (r_state == S_WRITE) ? (r_idx ? r_dat[15:0] : r_dat[31:16]) : '0;
  assign bus.hb_mask_o      = (r_state == S_WRITE) ? (r_idx ? ~r_sel[1:0] : ~r_sel[3:2]) : 2'b11;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed bench for hyperbus_wb_bridge; the controller side is driven by hand, cycle by cycle.
module tb_hyperbus_wb_bridge;

  localparam int unsigned TO = 16;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;
  int   cnt;

  hyperbus_wb_bridge_if #(.ADDR_LENGTH(32), .WB_ADR_WIDTH(32)) bus ();

  hyperbus_wb_bridge #(
    .ADDR_LENGTH(32), .WB_ADR_WIDTH(32), .REG_SPACE_BIT(31), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
  endtask

  task automatic wb_end();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;
    bus.hb_dat_i = '0;   bus.hb_ready_i = 1'b0; bus.hb_valid_i = 1'b0;
    tick(); tick();

    chk("rst_ack",  bus.wb_ack_o, 0);
    chk("rst_err",  bus.wb_err_o, 0);
    chk("rst_wrq",  bus.hb_wrq_o, 0);
    chk("rst_rrq",  bus.hb_rrq_o, 0);
    chk("rst_dato", bus.wb_dat_o, 0);
    chk("rst_adr",  bus.hb_adr_o, 0);
    chk("rst_hdat", bus.hb_dat_o, 0);
    chk("rst_mask", bus.hb_mask_o, 2'b11);
    chk("rst_reg",  bus.hb_reg_space_o, 0);
    rstn = 1'b1;
    tick();

    // Full write, both ready cycles back to back
    wb_start(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    tick();
    chk("w1_adr",   bus.hb_adr_o, 32'h8);
    chk("w1_wrq",   bus.hb_wrq_o, 1);
    chk("w1_dat0",  bus.hb_dat_o, 16'hDEAD);
    chk("w1_mask0", bus.hb_mask_o, 2'b00);
    chk("w1_ack0",  bus.wb_ack_o, 0);
    bus.hb_ready_i = 1'b1;
    tick();
    chk("w1_dat1",  bus.hb_dat_o, 16'hBEEF);
    chk("w1_mask1", bus.hb_mask_o, 2'b00);
    chk("w1_wrq1",  bus.hb_wrq_o, 1);
    tick();
    bus.hb_ready_i = 1'b0;
    chk("w1_wrqlo", bus.hb_wrq_o, 0);
    chk("w1_ack",   bus.wb_ack_o, 1);
    chk("w1_noerr", bus.wb_err_o, 0);
    wb_end();
    tick();
    chk("w1_ack1c", bus.wb_ack_o, 0);

    // Read with a three-cycle gap between valid words
    wb_start(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    chk("r1_adr", bus.hb_adr_o, 32'h10);
    chk("r1_rrq", bus.hb_rrq_o, 1);
    chk("r1_reg", bus.hb_reg_space_o, 0);
    bus.hb_valid_i = 1'b1; bus.hb_dat_i = 16'h1234;
    tick();
    bus.hb_valid_i = 1'b0; bus.hb_dat_i = 16'hFFFF;
    tick(); tick(); tick();
    chk("r1_rrqgap", bus.hb_rrq_o, 1);
    chk("r1_nogapack", bus.wb_ack_o, 0);
    bus.hb_valid_i = 1'b1; bus.hb_dat_i = 16'h5678;
    tick();
    bus.hb_valid_i = 1'b0;
    chk("r1_ack",  bus.wb_ack_o, 1);
    chk("r1_data", bus.wb_dat_o, 32'h1234_5678);
    chk("r1_rrqlo", bus.hb_rrq_o, 0);
    wb_end();
    tick();
    chk("r1_ack1c", bus.wb_ack_o, 0);

    // Partial byte enables map to inverted per-word masks
    wb_start(1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0010);
    tick();
    chk("w2_dat0",  bus.hb_dat_o, 16'hAABB);
    chk("w2_mask0", bus.hb_mask_o, 2'b11);
    bus.hb_ready_i = 1'b1;
    tick();
    chk("w2_dat1",  bus.hb_dat_o, 16'hCCDD);
    chk("w2_mask1", bus.hb_mask_o, 2'b01);
    tick();
    bus.hb_ready_i = 1'b0;
    chk("w2_ack", bus.wb_ack_o, 1);
    wb_end();
    tick();

    // Register-space read that is never served: expect err after TO cycles of rrq
    wb_start(1'b0, 32'h8000_0004, 32'h0, 4'hF);
    tick();
    chk("t_reg", bus.hb_reg_space_o, 1);
    chk("t_rrq", bus.hb_rrq_o, 1);
    chk("t_adr", bus.hb_adr_o, 32'h4000_0002);
    cnt = 0;
    while (!bus.wb_err_o && cnt < 40) begin
      if (bus.wb_ack_o) chk("t_spurack", bus.wb_ack_o, 0);
      cnt++;
      tick();
    end
    chk("t_cycles", cnt, TO);
    chk("t_err",    bus.wb_err_o, 1);
    chk("t_noack",  bus.wb_ack_o, 0);
    chk("t_rrqlo",  bus.hb_rrq_o, 0);
    wb_end();
    tick();
    chk("t_err1c", bus.wb_err_o, 0);
    chk("t_idle",  bus.hb_rrq_o, 0);

    // Abort a write after its first word, then a clean write
    wb_start(1'b1, 32'h0000_0060, 32'h1111_2222, 4'hF);
    tick();
    bus.hb_ready_i = 1'b1;
    tick();
    chk("a_dat1", bus.hb_dat_o, 16'h2222);
    bus.hb_ready_i = 1'b0;
    wb_end();
    tick();
    chk("a_wrqlo", bus.hb_wrq_o, 0);
    chk("a_noack", bus.wb_ack_o, 0);
    chk("a_noerr", bus.wb_err_o, 0);
    tick();
    chk("a_noack2", bus.wb_ack_o, 0);
    wb_start(1'b1, 32'h0000_0080, 32'h3333_4444, 4'hF);
    tick();
    chk("a2_adr",  bus.hb_adr_o, 32'h40);
    chk("a2_dat0", bus.hb_dat_o, 16'h3333);
    bus.hb_ready_i = 1'b1;
    tick();
    chk("a2_dat1", bus.hb_dat_o, 16'h4444);
    tick();
    bus.hb_ready_i = 1'b0;
    chk("a2_ack", bus.wb_ack_o, 1);
    wb_end();
    tick();

    // Asynchronous reset between the two words of a read
    wb_start(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    tick();
    bus.hb_valid_i = 1'b1; bus.hb_dat_i = 16'hABCD;
    tick();
    bus.hb_valid_i = 1'b0;
    chk("x_rrq", bus.hb_rrq_o, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("x_rrqrst",  bus.hb_rrq_o, 0);
    chk("x_datorst", bus.wb_dat_o, 0);
    chk("x_adrrst",  bus.hb_adr_o, 0);
    chk("x_maskrst", bus.hb_mask_o, 2'b11);
    tick();
    rstn = 1'b1;
    tick();
    chk("x2_rrq", bus.hb_rrq_o, 1);
    chk("x2_adr", bus.hb_adr_o, 32'h80);
    bus.hb_valid_i = 1'b1; bus.hb_dat_i = 16'h9876;
    tick();
    bus.hb_dat_i = 16'h5432;
    tick();
    bus.hb_valid_i = 1'b0;
    chk("x2_ack",  bus.wb_ack_o, 1);
    chk("x2_data", bus.wb_dat_o, 32'h9876_5432);
    wb_end();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
